// File: rtl/hex_display_scanner_if.sv
// Bus between the hex display scanner and its neighbours.
// The master side supplies the value and load strobe. The slave side (the scanner) drives the per-slot digit outputs.
interface hex_display_scanner_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value_in;
    logic                load;
    logic [3:0]          digit_hex;
    logic [DIGITS-1:0]   digit_sel;
    logic                digit_blank;
    logic                frame_tick;

    modport master (
        output value_in, load,
        input  digit_hex, digit_sel, digit_blank, frame_tick
    );

    modport slave (
        input  value_in, load,
        output digit_hex, digit_sel, digit_blank, frame_tick
    );
endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexes a latched multi-digit hex value onto a common-anode display, one digit per scan slot.
// Supports leading-zero blanking, an optional inter-digit gap and value updates only at frame boundaries.
module hex_display_scanner #(
    parameter int DIGITS        = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int GAP_CYCLES    = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    hex_display_scanner_if.slave  bus
);

    localparam int W    = 4 * DIGITS;
    localparam int CMAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int PW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] DRIVE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GAP_LAST   = PW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic {
        DRIVE = 1'b0,
        GAP   = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   pres, pres_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic            advance;
    logic            boundary;

    logic [W-1:0]    display_reg, display_nxt;
    logic [W-1:0]    pending_reg;
    logic            pending_valid;

    logic [3:0]        hex_nxt;
    logic [DIGITS-1:0] sel_nxt;
    logic              blank_nxt;

    function automatic logic [3:0] nibble(input logic [W-1:0] d, input logic [IW-1:0] i);
        return d[{i, 2'b00} +: 4];
    endfunction

    // A digit is a leading zero when it and every more-significant nibble are zero.
    function automatic logic leading_zero(input logic [W-1:0] d, input logic [IW-1:0] i);
        return (BLANK_LEADING != 0) && (i != '0) && ((d >> {i, 2'b00}) == '0);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DRIVE;
            pres  <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            pres  <= pres_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pres_nxt  = pres + PW'(1);
        advance   = 1'b0;
        case (state)
            DRIVE: begin
                if (pres == DRIVE_LAST) begin
                    pres_nxt = '0;
                    if (GAP_CYCLES > 0) state_nxt = GAP;
                    else                advance   = 1'b1;
                end
            end
            GAP: begin
                if (pres == GAP_LAST) begin
                    pres_nxt  = '0;
                    state_nxt = DRIVE;
                    advance   = 1'b1;
                end
            end
            default: state_nxt = DRIVE;
        endcase
        idx_nxt = idx;
        if (advance) idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        boundary = advance && (idx == IDX_LAST);
    end

    // A load coinciding with the boundary goes straight to the display; otherwise it waits in pending_reg.
    always_comb begin
        display_nxt = display_reg;
        if (boundary) begin
            if (bus.load)           display_nxt = bus.value_in;
            else if (pending_valid) display_nxt = pending_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            display_reg   <= '0;
            pending_reg   <= '0;
            pending_valid <= 1'b0;
        end else begin
            display_reg <= display_nxt;
            if (boundary) begin
                pending_valid <= 1'b0;
            end else if (bus.load) begin
                pending_reg   <= bus.value_in;
                pending_valid <= 1'b1;
            end
        end
    end

    // Outputs are decoded from the upcoming state so the registered outputs line up with the state they describe.
    always_comb begin
        hex_nxt   = '0;
        sel_nxt   = '1;
        blank_nxt = 1'b1;
        if (state_nxt == DRIVE && !leading_zero(display_nxt, idx_nxt)) begin
            hex_nxt          = nibble(display_nxt, idx_nxt);
            sel_nxt[idx_nxt] = 1'b0;
            blank_nxt        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.digit_hex   <= '0;
            bus.digit_sel   <= ~(DIGITS'(1));
            bus.digit_blank <= 1'b0;
            bus.frame_tick  <= 1'b0;
        end else begin
            bus.digit_hex   <= hex_nxt;
            bus.digit_sel   <= sel_nxt;
            bus.digit_blank <= blank_nxt;
            bus.frame_tick  <= boundary;
        end
    end

endmodule
